// File: rtl/art_pkg.sv
// rtl/art_pkg.sv - Mode encodings, FSM states and default art for the marquee tile.
package art_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STATIC = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_STATIC,
        ST_SCROLL,
        ST_BLINK_ON,
        ST_BLINK_OFF
    } art_state_t;

    localparam logic [7:0] ART_DEFAULT [0:15] = '{
        8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hDB, 8'h99, 8'h81, 8'h42,
        8'h24, 8'h5A, 8'hA5, 8'hC3, 8'hE7, 8'h66, 8'h3C, 8'h18
    };

    // Mode that keeps the FSM in its current state; any other mode is a change.
    function automatic logic [1:0] state_mode(input art_state_t s);
        case (s)
            ST_STATIC:                 state_mode = MODE_STATIC;
            ST_SCROLL:                 state_mode = MODE_SCROLL;
            ST_BLINK_ON, ST_BLINK_OFF: state_mode = MODE_BLINK;
            default:                   state_mode = MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/art_prescaler.sv
// rtl/art_prescaler.sv - Programmable tick divider; one-cycle tick every TICK_DIV enabled cycles.
module art_prescaler #(
    parameter int DIV_W    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_um_art_marquee.sv
// rtl/tt_um_art_marquee.sv - Writable pattern marquee (off/static/scroll/blink) for TinyTapeout.
// Optional ART_TICK_OUT_EN drives the registered tick onto uio_out[0].
module tt_um_art_marquee
    import art_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DIV_W    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]        ui_q;
    logic [7:0]        uio_q;
    logic              strobe_prev_q;
    logic [7:0]        pattern_q [DEPTH];
    art_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        uo_q, uo_d;

    logic [1:0]        mode;
    logic              mode_change;
    logic              we;
    logic              tick;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] addr_step;

    assign mode        = ui_q[1:0];
    assign mode_change = (mode != state_mode(state_q));
    assign we          = ena && ui_q[3] && !strobe_prev_q;
    assign wr_addr     = ui_q[4 +: ADDR_W];
    assign addr_step   = ui_q[2] ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ui_q          <= '0;
            uio_q         <= '0;
            strobe_prev_q <= 1'b0;
        end else if (ena) begin
            ui_q          <= ui_in;
            uio_q         <= uio_in;
            strobe_prev_q <= ui_q[3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pattern_q[i] <= ART_DEFAULT[i];
            end
        end else if (we) begin
            pattern_q[wr_addr] <= uio_q;
        end
    end

    art_prescaler #(
        .DIV_W    (DIV_W),
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ena),
        .clr  (mode_change || (state_q == ST_OFF)),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (mode_change) begin
            case (mode)
                MODE_OFF:    begin state_d = ST_OFF;    addr_d = '0; end
                MODE_STATIC: begin state_d = ST_STATIC; addr_d = '0; end
                MODE_SCROLL: state_d = ST_SCROLL;
                default:     state_d = ST_BLINK_ON;
            endcase
        end else begin
            case (state_q)
                ST_SCROLL:    if (tick) addr_d = addr_step;
                ST_BLINK_ON:  if (tick) state_d = ST_BLINK_OFF;
                ST_BLINK_OFF: if (tick) begin
                    state_d = ST_BLINK_ON;
                    addr_d  = addr_step;
                end
                default:      addr_d = '0;
            endcase
        end

        // Reads the pre-write memory, so a same-cycle write shows up one update later.
        case (state_d)
            ST_STATIC:               uo_d = pattern_q[0];
            ST_SCROLL, ST_BLINK_ON:  uo_d = pattern_q[addr_d];
            default:                 uo_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            addr_q  <= '0;
            uo_q    <= '0;
        end else if (ena) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out = uo_q;

`ifdef ART_TICK_OUT_EN
    logic tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign uio_out = {7'b0, tick_q};
    assign uio_oe  = 8'h01;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_art_marquee.sv
// tb/tb_tt_um_art_marquee.sv - Directed self-checking bench for the marquee tile.
module tb_tt_um_art_marquee;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_a, uio_out_a, uio_oe_a;
    logic [7:0] uo_b, uio_out_b, uio_oe_b;

    int checks = 0;
    int errors = 0;

`ifdef ART_TICK_OUT_EN
    localparam logic [7:0] OE_EXP = 8'h01;
`else
    localparam logic [7:0] OE_EXP = 8'h00;
`endif

    always #5 clk = ~clk;

    tt_um_art_marquee #(.DEPTH(4), .DIV_W(8), .TICK_DIV(4)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_a),
        .uio_out (uio_out_a),
        .uio_oe  (uio_oe_a)
    );

    tt_um_art_marquee #(.DEPTH(4), .DIV_W(8), .TICK_DIV(3)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_b),
        .uio_out (uio_out_b),
        .uio_oe  (uio_oe_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        step(3);
        chk("reset_uo", uo_a, 8'h00);
        chk("reset_uio_out", uio_out_a, 8'h00);
        chk("reset_uio_oe", uio_oe_a, OE_EXP);
        rst = 1'b0;
        step(2);
        chk("off_uo", uo_a, 8'h00);

        // Scroll up from defaults, then reverse direction across the 0->3 wrap
        ui_in = 8'h02;
        step(2); chk("scroll_up0", uo_a, 8'h18);
        step(3); chk("scroll_hold", uo_a, 8'h18);
        step(1); chk("scroll_up1", uo_a, 8'h3C);
        step(4); chk("scroll_up2", uo_a, 8'h7E);
        step(4); chk("scroll_up3", uo_a, 8'hFF);
        step(4); chk("scroll_wrap", uo_a, 8'h18);
        ui_in = 8'h06;
        step(4); chk("scroll_dn3", uo_a, 8'hFF);
        step(4); chk("scroll_dn2", uo_a, 8'h7E);
        step(4); chk("scroll_dn1", uo_a, 8'h3C);
        ui_in = 8'h00;
        step(3); chk("off_again", uo_a, 8'h00);

        // Held strobe: data changes mid-hold must not be written again
        ui_in = 8'h28; uio_in = 8'hA5;
        step(3);
        uio_in = 8'h5A;
        step(7);
        ui_in = 8'h00;
        step(2);
        // Address 4'hD aliases to index 1 with DEPTH=4
        ui_in = 8'hD8; uio_in = 8'h77;
        step(3);
        ui_in = 8'h00;
        step(2);
        ui_in = 8'h01;
        step(2); chk("static", uo_a, 8'h18);
        ui_in = 8'h02;
        step(2); chk("wr_scroll0", uo_a, 8'h18);
        step(4); chk("wr_alias1", uo_a, 8'h77);
        step(4); chk("wr_once2", uo_a, 8'hA5);
        step(4); chk("wr_scroll3", uo_a, 8'hFF);

        // Blink on the TICK_DIV=3 instance
        ui_in = 8'h00;
        step(2);
        ui_in = 8'h03;
        step(2); chk("blink_on0", uo_b, 8'h18);
        step(2); chk("blink_on0_hold", uo_b, 8'h18);
        step(1); chk("blink_off0", uo_b, 8'h00);
        step(2); chk("blink_off0_hold", uo_b, 8'h00);
        step(1); chk("blink_on1", uo_b, 8'h77);
        step(3); chk("blink_off1", uo_b, 8'h00);
        step(3); chk("blink_on2", uo_b, 8'hA5);

        // Freeze mid-count with ena low; a strobe pulse meanwhile is ignored
        ui_in = 8'h00;
        step(2);
        ui_in = 8'h02;
        step(2); chk("ena_start", uo_a, 8'h18);
        step(2);
        ena = 1'b0;
        ui_in = 8'h0A; uio_in = 8'hEE;
        step(2);
        ui_in = 8'h02;
        step(18); chk("ena_frozen", uo_a, 8'h18);
        ena = 1'b1;
        step(1); chk("ena_resume_cnt3", uo_a, 8'h18);
        step(1); chk("ena_resume_step", uo_a, 8'h77);
        step(4); chk("ena_scroll2", uo_a, 8'hA5);
        step(4); chk("ena_scroll3", uo_a, 8'hFF);
        step(4); chk("ena_no_write", uo_a, 8'h18);

        // Write during scroll, then reset restores the default art
        ui_in = 8'h3A; uio_in = 8'h3E;
        step(3);
        ui_in = 8'h02;
        step(2);
        rst = 1'b1;
        step(1); chk("rst_mid_uo", uo_a, 8'h00);
        chk("rst_mid_uio_out", uio_out_a, 8'h00);
        step(1);
        rst = 1'b0;
        step(2); chk("post_rst0", uo_a, 8'h18);
        step(4); chk("post_rst1", uo_a, 8'h3C);
        step(4); chk("post_rst2", uo_a, 8'h7E);
        step(4); chk("post_rst3", uo_a, 8'hFF);
        chk("final_uio_oe", uio_oe_b, OE_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
